cpu_clk_rst_ctrl: RTL and testbench
===================================

Name: cpu_clk_rst_ctrl

Overview:
Clock-enable and reset sequencer for the pipelined MIPS CPU. It replaces bench-driven reset pulses and the fixed ctrl/mem clock split with one synthesizable block on sysclk. The block generates a power-on reset, reruns reset on software request or after a programmable run length, and produces phase-aligned ctrl/mem clock enables at parametrised ratios. It sits between the board clock/reset and the CPU top.

Parameters:
POR_CYCLES, 4, sysclk cycles that cpu_reset is held after async reset deassertion (>=1)
RST_CYCLES, 2, sysclk cycles that cpu_reset is held for each rerun reset (>=1)
MEM_DIV, 1, mem_ce period in sysclk cycles (>=1)
CTRL_DIV, 2, ctrl_ce period in sysclk cycles; must be an integer multiple of MEM_DIV
RERUN_PERIOD, 1000, ctrl_ce ticks in RUN before an automatic re-reset; 0 disables it
CNT_W, 16, width of run_cnt; must satisfy 2^CNT_W > RERUN_PERIOD

Ports:
sysclk  in  1  single system clock; all logic is on the rising edge
reset  in  1  asynchronous, active-low block reset
soft_rst_req  in  1  single-cycle request to rerun the CPU reset
rerun_en  in  1  enables the periodic re-reset (level)
cpu_reset  out  1  active-high reset to the CPU
ctrl_ce  out  1  one-sysclk-wide pipeline clock enable
mem_ce  out  1  one-sysclk-wide memory clock enable
run_cnt  out  CNT_W  ctrl_ce ticks since the last reset release; saturates at all-ones
rst_count  out  8  number of rerun resets issued; wraps
state  out  2  00=POR, 01=RST, 10=RUN

Behaviour:
- reset low (async): state=POR, cpu_reset=1, ctrl_ce=0, mem_ce=0, run_cnt=0, rst_count=0, all internal counters=0. Every output is registered.
- POR state: counts sysclk cycles. After POR_CYCLES cycles following reset release, the next state is RUN. cpu_reset=1 and both enables are 0 throughout.
- RST state: identical behaviour, using RST_CYCLES. Entry increments rst_count by 1 in the same edge.
- Transition to RUN: cpu_reset falls on the same edge. The mem and ctrl phase counters and run_cnt clear to 0.
- RUN state: the phase counters increment each sysclk and wrap at DIV-1.
  - mem_ce=1 in the cycle where the mem phase equals MEM_DIV-1. With MEM_DIV=1, mem_ce is held high throughout RUN.
  - ctrl_ce follows the same rule with CTRL_DIV.
  - Every ctrl_ce pulse coincides with a mem_ce pulse. The first ctrl_ce is in the CTRL_DIV-th RUN cycle.
- run_cnt increments on each ctrl_ce in RUN and saturates.
- Periodic rerun: if rerun_en=1, RERUN_PERIOD!=0, ctrl_ce=1 and run_cnt==RERUN_PERIOD-1, the next state is RST. That ctrl_ce is the last enable issued, and run_cnt is not incremented.
- soft_rst_req=1 in RUN: the next state is RST. cpu_reset=1 and enables=0 from the next cycle.
- soft_rst_req is ignored in POR and RST; it does not extend the pulse or count again.
- A soft request and a periodic trigger in the same cycle produce one RST entry; rst_count increments by 1.
- rerun_en deasserted in RUN: run_cnt keeps counting and saturates; no automatic reset occurs.
- Async reset in any state returns the block to POR immediately. rst_count clears.
- No combinational path from any input to any output.

Test Plan:
1. Defaults, reset low for 3 cycles then released -> cpu_reset=1 for exactly 4 sysclk. State goes to RUN; mem_ce is constant 1; the first ctrl_ce is on the 2nd RUN cycle and then every 2 cycles after.
2. MEM_DIV=2, CTRL_DIV=6 -> in RUN, mem_ce on cycles 2,4,6,… and ctrl_ce on cycles 6,12,…; every ctrl_ce coincides with a mem_ce.
3. RERUN_PERIOD=5, rerun_en=1 -> after the 5th ctrl_ce (run_cnt=4 at that edge), state=RST and cpu_reset=1 for 2 cycles. rst_count=1; run_cnt=0 and ctrl phase=0 on RUN re-entry.
4. soft_rst_req pulse in RUN at run_cnt=3 -> next cycle cpu_reset=1, rst_count+1. A second pulse during RST has no effect (pulse stays 2 cycles, count unchanged).
5. soft_rst_req on the same cycle as the periodic trigger -> one RST entry; rst_count increases by exactly 1.
6. Async reset dropped mid-RST with rst_count=3 -> outputs go to reset values before the next edge. On release, the POR length is 4 cycles and rst_count=0.

Source files
------------

// File: rtl/cpu_clk_rst_ctrl.sv
//=============================================================================
// Module   : cpu_clk_rst_ctrl
// Brief    : Reset sequencer and ctrl/mem clock-enable generator for the
//            pipelined MIPS CPU. Produces a power-on reset, reruns the CPU
//            reset on request or after a programmable run length, and issues
//            phase-aligned ctrl/mem clock enables on sysclk.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module cpu_clk_rst_ctrl #(
   parameter int POR_CYCLES   = 4,
   parameter int RST_CYCLES   = 2,
   parameter int MEM_DIV      = 1,
   parameter int CTRL_DIV     = 2,
   parameter int RERUN_PERIOD = 1000,
   parameter int CNT_W        = 16
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             soft_rst_req,
   input  logic             rerun_en,
   output logic             cpu_reset,
   output logic             ctrl_ce,
   output logic             mem_ce,
   output logic [CNT_W-1:0] run_cnt,
   output logic [7:0]       rst_count,
   output logic [1:0]       state
);

   localparam logic [1:0] ST_POR = 2'b00;
   localparam logic [1:0] ST_RST = 2'b01;
   localparam logic [1:0] ST_RUN = 2'b10;

   localparam int SEQ_MAX = (POR_CYCLES > RST_CYCLES) ? POR_CYCLES : RST_CYCLES;
   localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
   localparam int MEM_W   = $clog2(MEM_DIV + 1);
   localparam int CTRL_W  = $clog2(CTRL_DIV + 1);

   localparam logic [SEQ_W-1:0]  C_POR_LAST   = SEQ_W'(POR_CYCLES - 1);
   localparam logic [SEQ_W-1:0]  C_RST_LAST   = SEQ_W'(RST_CYCLES - 1);
   localparam logic [MEM_W-1:0]  C_MEM_LAST   = MEM_W'(MEM_DIV - 1);
   localparam logic [CTRL_W-1:0] C_CTRL_LAST  = CTRL_W'(CTRL_DIV - 1);
   // With RERUN_PERIOD=0 this wraps to all-ones, but C_RERUN_ON masks it off.
   localparam logic [CNT_W-1:0]  C_RERUN_LAST = CNT_W'(RERUN_PERIOD - 1);
   localparam logic              C_RERUN_ON   = (RERUN_PERIOD != 0);

   logic [1:0]        state_q,     state_d;
   logic [SEQ_W-1:0]  seq_q,       seq_d;
   logic [MEM_W-1:0]  mem_ph_q,    mem_ph_d;
   logic [CTRL_W-1:0] ctrl_ph_q,   ctrl_ph_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              mem_ce_q,    mem_ce_d;
   logic              ctrl_ce_q,   ctrl_ce_d;
   logic [CNT_W-1:0]  run_cnt_q,   run_cnt_d;
   logic [7:0]        rst_count_q, rst_count_d;

   logic w_periodic;
   logic w_run_next;
   logic w_run_stay;
   logic w_run_enter;
   logic w_rst_enter;

   // The periodic trigger looks at the enable already on the output, so the
   // ctrl_ce that fires it is the last one the CPU sees before reset.
   assign w_periodic  = rerun_en & C_RERUN_ON & ctrl_ce_q & (run_cnt_q == C_RERUN_LAST);
   assign w_run_next  = (state_d == ST_RUN);
   assign w_run_stay  = (state_q == ST_RUN) & w_run_next;
   assign w_run_enter = (state_q != ST_RUN) & w_run_next;
   assign w_rst_enter = (state_q == ST_RUN) & (state_d == ST_RST);

   // State and registered-output flops; async active-low block reset
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_POR;
         seq_q       <= '0;
         mem_ph_q    <= '0;
         ctrl_ph_q   <= '0;
         cpu_reset_q <= 1'b1;
         mem_ce_q    <= 1'b0;
         ctrl_ce_q   <= 1'b0;
         run_cnt_q   <= '0;
         rst_count_q <= '0;
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         mem_ph_q    <= mem_ph_d;
         ctrl_ph_q   <= ctrl_ph_d;
         cpu_reset_q <= cpu_reset_d;
         mem_ce_q    <= mem_ce_d;
         ctrl_ce_q   <= ctrl_ce_d;
         run_cnt_q   <= run_cnt_d;
         rst_count_q <= rst_count_d;
      end
   end

   // Next-state: reset states time out into RUN; RUN leaves on request or period
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_POR: if (seq_q == C_POR_LAST) state_d = ST_RUN;
         ST_RST: if (seq_q == C_RST_LAST) state_d = ST_RUN;
         ST_RUN: if (soft_rst_req || w_periodic) state_d = ST_RST;
         default: state_d = ST_POR;
      endcase
   end

   // Next values of counters and outputs, all derived from the next state so
   // every output is a flop and enables line up with the state they belong to
   always_comb begin
      // Cycles spent in the current reset state; restarts on every state change
      seq_d = '0;
      if ((state_q != ST_RUN) && (state_d == state_q)) begin
         seq_d = seq_q + 1'b1;
      end

      // Phase counters start at 0 in the first RUN cycle and wrap at DIV-1
      mem_ph_d = '0;
      if (w_run_stay && (mem_ph_q != C_MEM_LAST)) begin
         mem_ph_d = mem_ph_q + 1'b1;
      end
      ctrl_ph_d = '0;
      if (w_run_stay && (ctrl_ph_q != C_CTRL_LAST)) begin
         ctrl_ph_d = ctrl_ph_q + 1'b1;
      end

      mem_ce_d    = w_run_next && (mem_ph_d == C_MEM_LAST);
      ctrl_ce_d   = w_run_next && (ctrl_ph_d == C_CTRL_LAST);
      cpu_reset_d = ~w_run_next;

      // Count ctrl_ce ticks while staying in RUN; hold through reset states
      run_cnt_d = run_cnt_q;
      if (w_run_enter) begin
         run_cnt_d = '0;
      end else if (w_run_stay && ctrl_ce_q && (run_cnt_q != {CNT_W{1'b1}})) begin
         run_cnt_d = run_cnt_q + 1'b1;
      end

      rst_count_d = rst_count_q + {7'd0, w_rst_enter};
   end

   assign cpu_reset = cpu_reset_q;
   assign ctrl_ce   = ctrl_ce_q;
   assign mem_ce    = mem_ce_q;
   assign run_cnt   = run_cnt_q;
   assign rst_count = rst_count_q;
   assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_clk_rst_ctrl.sv
//=============================================================================
// Module   : tb_cpu_clk_rst_ctrl
// Brief    : Self-checking bench for cpu_clk_rst_ctrl. Three instances with
//            different ratios/periods share one stimulus stream and are
//            compared against a cycle-count reference model.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_cpu_clk_rst_ctrl;

   localparam int NI   = 3;
   localparam int POR  = 4;
   localparam int RSTC = 2;
   localparam logic [28:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 8'h00};

   logic sysclk = 1'b0;
   logic reset;
   logic soft_rst_req = 1'b0;
   logic rerun_en = 1'b0;

   logic [NI-1:0] d_cpu_reset, d_ctrl, d_mem;
   logic [15:0]   d_run_cnt   [NI];
   logic [7:0]    d_rst_count [NI];
   logic [1:0]    d_state     [NI];

   int vectors = 0;
   int miscompares = 0;

   // Reference model: phase 0=POR 1=RST 2=RUN, cycles left in reset phase,
   // 1-based RUN cycle index, ctrl ticks since release, rerun count
   int m_ph [NI];
   int m_left [NI];
   int m_k [NI];
   int m_ticks [NI];
   int m_rcnt [NI];

   always #5 sysclk = ~sysclk;

   cpu_clk_rst_ctrl u_dflt (
      .sysclk(sysclk), .reset(reset), .soft_rst_req(soft_rst_req), .rerun_en(rerun_en),
      .cpu_reset(d_cpu_reset[0]), .ctrl_ce(d_ctrl[0]), .mem_ce(d_mem[0]),
      .run_cnt(d_run_cnt[0]), .rst_count(d_rst_count[0]), .state(d_state[0]));

   cpu_clk_rst_ctrl #(.MEM_DIV(2), .CTRL_DIV(6), .RERUN_PERIOD(5)) u_div (
      .sysclk(sysclk), .reset(reset), .soft_rst_req(soft_rst_req), .rerun_en(rerun_en),
      .cpu_reset(d_cpu_reset[1]), .ctrl_ce(d_ctrl[1]), .mem_ce(d_mem[1]),
      .run_cnt(d_run_cnt[1]), .rst_count(d_rst_count[1]), .state(d_state[1]));

   cpu_clk_rst_ctrl #(.RERUN_PERIOD(5)) u_rr (
      .sysclk(sysclk), .reset(reset), .soft_rst_req(soft_rst_req), .rerun_en(rerun_en),
      .cpu_reset(d_cpu_reset[2]), .ctrl_ce(d_ctrl[2]), .mem_ce(d_mem[2]),
      .run_cnt(d_run_cnt[2]), .rst_count(d_rst_count[2]), .state(d_state[2]));

   function automatic int p_mdiv(int i);
      return (i == 1) ? 2 : 1;
   endfunction
   function automatic int p_cdiv(int i);
      return (i == 1) ? 6 : 2;
   endfunction
   function automatic int p_rp(int i);
      return (i == 0) ? 1000 : 5;
   endfunction

   function automatic logic [28:0] exp_vec(int i);
      logic       run;
      logic [1:0] st;
      run = (m_ph[i] == 2);
      st  = (m_ph[i] == 0) ? 2'b00 : (m_ph[i] == 1) ? 2'b01 : 2'b10;
      return {~run, run && (m_k[i] % p_cdiv(i) == 0), run && (m_k[i] % p_mdiv(i) == 0),
              st, 16'(m_ticks[i]), 8'(m_rcnt[i])};
   endfunction

   function automatic logic [28:0] act_vec(int i);
      return {d_cpu_reset[i], d_ctrl[i], d_mem[i], d_state[i], d_run_cnt[i], d_rst_count[i]};
   endfunction

   task automatic model_async_reset();
      for (int i = 0; i < NI; i++) begin
         m_ph[i] = 0; m_left[i] = POR; m_k[i] = 0; m_ticks[i] = 0; m_rcnt[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         if (m_ph[i] != 2) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
               m_ph[i] = 2; m_k[i] = 1; m_ticks[i] = 0;
            end
         end else begin
            bit ctrl;
            bit trig;
            ctrl = (m_k[i] % p_cdiv(i) == 0);
            trig = rerun_en && (p_rp(i) != 0) && ctrl && (m_ticks[i] == p_rp(i) - 1);
            if (soft_rst_req || trig) begin
               m_ph[i] = 1; m_left[i] = RSTC; m_rcnt[i] = (m_rcnt[i] + 1) % 256;
            end else begin
               if (ctrl && m_ticks[i] < 65535) m_ticks[i]++;
               m_k[i]++;
            end
         end
      end
   endtask

   // One rising edge (model follows it) then land on the sampling negedge
   task automatic cyc();
      @(posedge sysclk);
      if (reset === 1'b1) model_edge();
      @(negedge sysclk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      model_async_reset();
      for (int c = 0; c < 3; c++) begin
         cyc();
         for (int i = 0; i < NI; i++) begin
            vectors++;
            if (act_vec(i) !== RESET_VEC) begin
               miscompares++;
               $display("FAIL reset_values inst%0d: got %h expected %h", i, act_vec(i), RESET_VEC);
            end
         end
      end
   endtask

   task automatic test_por_and_ratios();
      int hi = 0;
      int n = 0;
      @(posedge sysclk);
      #1 reset = 1'b1;
      @(negedge sysclk);
      while (d_cpu_reset[0] === 1'b1 && n < 20) begin
         hi++; n++;
         for (int i = 0; i < NI; i++) begin
            vectors++;
            if (act_vec(i) !== exp_vec(i)) begin
               miscompares++;
               $display("FAIL por_model inst%0d t=%0t: got %h expected %h", i, $time, act_vec(i), exp_vec(i));
            end
         end
         cyc();
      end
      vectors++;
      if (hi != POR) begin
         miscompares++;
         $display("FAIL por_length: got %0d cycles expected %0d", hi, POR);
      end
      for (int j = 1; j <= 24; j++) begin
         logic [3:0] want;
         want = {1'b1, (j % 2 == 0), (j % 2 == 0), (j % 6 == 0)};
         vectors++;
         if ({d_mem[0], d_ctrl[0], d_mem[1], d_ctrl[1]} !== want) begin
            miscompares++;
            $display("FAIL ratio_pattern run_cycle=%0d: got %b expected %b", j,
                     {d_mem[0], d_ctrl[0], d_mem[1], d_ctrl[1]}, want);
         end
         vectors++;
         if (d_ctrl[1] === 1'b1 && d_mem[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL ratio_coincide run_cycle=%0d: got mem_ce=%b expected 1", j, d_mem[1]);
         end
         for (int i = 0; i < NI; i++) begin
            vectors++;
            if (act_vec(i) !== exp_vec(i)) begin
               miscompares++;
               $display("FAIL ratio_model inst%0d t=%0t: got %h expected %h", i, $time, act_vec(i), exp_vec(i));
            end
         end
         cyc();
      end
   endtask

   task automatic test_soft_rst();
      int n = 0;
      int hi;
      int prev;
      soft_rst_req = 1'b1; cyc(); soft_rst_req = 1'b0;
      for (int i = 0; i < NI; i++) begin
         vectors++;
         if (d_state[i] !== 2'b01) begin
            miscompares++;
            $display("FAIL soft_enter inst%0d: got state %b expected 01", i, d_state[i]);
         end
      end
      while (!(d_state[0] === 2'b10 && d_run_cnt[0] === 16'd3) && n < 50) begin
         n++;
         for (int i = 0; i < NI; i++) begin
            vectors++;
            if (act_vec(i) !== exp_vec(i)) begin
               miscompares++;
               $display("FAIL soft_model inst%0d t=%0t: got %h expected %h", i, $time, act_vec(i), exp_vec(i));
            end
         end
         cyc();
      end
      vectors++;
      if (n >= 50) begin
         miscompares++;
         $display("FAIL soft_wait: got timeout expected run_cnt=3 in RUN");
      end
      prev = m_rcnt[0];
      soft_rst_req = 1'b1; cyc(); soft_rst_req = 1'b0;
      vectors++;
      if ({d_cpu_reset[0], d_rst_count[0]} !== {1'b1, 8'(prev + 1)}) begin
         miscompares++;
         $display("FAIL soft_pulse: got cpu_reset=%b rst_count=%0d expected 1/%0d",
                  d_cpu_reset[0], d_rst_count[0], prev + 1);
      end
      hi = 1;
      n  = 0;
      soft_rst_req = 1'b1; cyc(); soft_rst_req = 1'b0;
      while (d_cpu_reset[0] === 1'b1 && n < 10) begin
         hi++; n++;
         cyc();
      end
      vectors++;
      if (hi != RSTC) begin
         miscompares++;
         $display("FAIL soft_rst_length: got %0d cycles expected %0d", hi, RSTC);
      end
      vectors++;
      if (d_rst_count[0] !== 8'(prev + 1)) begin
         miscompares++;
         $display("FAIL soft_ignored_in_rst: got rst_count=%0d expected %0d", d_rst_count[0], prev + 1);
      end
   endtask

   task automatic test_periodic();
      int n = 0;
      int hi = 0;
      int prev;
      logic        lc = 1'b0;
      logic [15:0] lr = '0;
      rerun_en = 1'b1;
      prev = m_rcnt[2];
      while (d_state[2] !== 2'b01 && n < 40) begin
         lc = d_ctrl[2]; lr = d_run_cnt[2]; n++;
         for (int i = 0; i < NI; i++) begin
            vectors++;
            if (act_vec(i) !== exp_vec(i)) begin
               miscompares++;
               $display("FAIL periodic_model inst%0d t=%0t: got %h expected %h", i, $time, act_vec(i), exp_vec(i));
            end
         end
         cyc();
      end
      vectors++;
      if (n != 10) begin
         miscompares++;
         $display("FAIL periodic_run_len: got %0d RUN cycles expected 10", n);
      end
      vectors++;
      if ({lc, lr} !== {1'b1, 16'd4}) begin
         miscompares++;
         $display("FAIL periodic_last_tick: got ctrl_ce=%b run_cnt=%0d expected 1/4", lc, lr);
      end
      vectors++;
      if (d_rst_count[2] !== 8'(prev + 1)) begin
         miscompares++;
         $display("FAIL periodic_rst_count: got %0d expected %0d", d_rst_count[2], prev + 1);
      end
      n = 0;
      while (d_cpu_reset[2] === 1'b1 && n < 10) begin
         hi++; n++;
         cyc();
      end
      vectors++;
      if (hi != RSTC) begin
         miscompares++;
         $display("FAIL periodic_rst_length: got %0d cycles expected %0d", hi, RSTC);
      end
      vectors++;
      if ({d_state[2], d_run_cnt[2], d_ctrl[2]} !== {2'b10, 16'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL periodic_reentry: got state=%b run_cnt=%0d ctrl_ce=%b expected 10/0/0",
                  d_state[2], d_run_cnt[2], d_ctrl[2]);
      end
      cyc();
      vectors++;
      if (d_ctrl[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL periodic_first_ctrl: got %b expected 1", d_ctrl[2]);
      end
   endtask

   task automatic test_coincident();
      int n = 0;
      int prev;
      while (!(m_ph[2] == 2 && (m_k[2] % p_cdiv(2) == 0) && m_ticks[2] == 4) && n < 40) begin
         n++;
         cyc();
      end
      prev = m_rcnt[2];
      soft_rst_req = 1'b1; cyc(); soft_rst_req = 1'b0;
      vectors++;
      if ({d_state[2], d_rst_count[2]} !== {2'b01, 8'(prev + 1)}) begin
         miscompares++;
         $display("FAIL coincident_entry: got state=%b rst_count=%0d expected 01/%0d",
                  d_state[2], d_rst_count[2], prev + 1);
      end
      cyc(); cyc();
      vectors++;
      if ({d_state[2], d_rst_count[2]} !== {2'b10, 8'(prev + 1)}) begin
         miscompares++;
         $display("FAIL coincident_single: got state=%b rst_count=%0d expected 10/%0d",
                  d_state[2], d_rst_count[2], prev + 1);
      end
   endtask

   task automatic test_async();
      int n;
      int hi = 0;
      rerun_en = 1'b0;
      reset = 1'b0; model_async_reset();
      #1;
      for (int i = 0; i < NI; i++) begin
         vectors++;
         if (act_vec(i) !== RESET_VEC) begin
            miscompares++;
            $display("FAIL async_in_run inst%0d: got %h expected %h", i, act_vec(i), RESET_VEC);
         end
      end
      cyc();
      @(posedge sysclk);
      #1 reset = 1'b1;
      @(negedge sysclk);
      for (int p = 0; p < 3; p++) begin
         n = 0;
         while (d_state[2] !== 2'b10 && n < 20) begin
            n++;
            cyc();
         end
         soft_rst_req = 1'b1; cyc(); soft_rst_req = 1'b0;
      end
      vectors++;
      if ({d_state[2], d_rst_count[2]} !== {2'b01, 8'd3}) begin
         miscompares++;
         $display("FAIL async_setup: got state=%b rst_count=%0d expected 01/3", d_state[2], d_rst_count[2]);
      end
      #2 reset = 1'b0;
      model_async_reset();
      #1;
      for (int i = 0; i < NI; i++) begin
         vectors++;
         if (act_vec(i) !== RESET_VEC) begin
            miscompares++;
            $display("FAIL async_in_rst inst%0d: got %h expected %h", i, act_vec(i), RESET_VEC);
         end
      end
      cyc(); cyc();
      @(posedge sysclk);
      #1 reset = 1'b1;
      @(negedge sysclk);
      n = 0;
      while (d_cpu_reset[2] === 1'b1 && n < 20) begin
         hi++; n++;
         cyc();
      end
      vectors++;
      if (hi != POR) begin
         miscompares++;
         $display("FAIL async_por_length: got %0d cycles expected %0d", hi, POR);
      end
      vectors++;
      if ({d_state[2], d_rst_count[2]} !== {2'b10, 8'd0}) begin
         miscompares++;
         $display("FAIL async_release: got state=%b rst_count=%0d expected 10/0", d_state[2], d_rst_count[2]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         soft_rst_req = ($urandom_range(15) == 0);
         if ($urandom_range(31) == 0) rerun_en = ~rerun_en;
         cyc();
         for (int i = 0; i < NI; i++) begin
            vectors++;
            if (act_vec(i) !== exp_vec(i)) begin
               miscompares++;
               $display("FAIL random_model inst%0d t=%0t: got %h expected %h", i, $time, act_vec(i), exp_vec(i));
            end
         end
      end
      soft_rst_req = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion expected finish before %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_por_and_ratios();
      test_soft_rst();
      test_periodic();
      test_coincident();
      test_async();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
